reg_writeback: RTL and testbench

- Write-back end of the operand path. The operand latches read from the register bank; this block writes ALU results back into it.
- Accepts results with a valid/ready handshake and buffers them in a small in-order queue.
- Drives the register bank write port, which has its own ready.
- Provides a combinational forwarding lookup. This lets the operand stages see results that are still queued.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/reg_writeback_if.sv | 37 +++
 rtl/wb_fwd_match.sv | 32 +++
 rtl/reg_writeback.sv | 81 ++++++++
 tb/tb_reg_writeback.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and the write-back queue entry type.
package cpu_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;
    localparam int ADDR_W     = REG_ADDR_W;
    localparam int NUM_REGS   = 1 << ADDR_W;

    // Register 0 is the accumulator; the write-back path gives it no special treatment.
    localparam logic [ADDR_W-1:0] ACC_ADDR = '0;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/reg_writeback_if.sv
// Result-in / register-bank-out / forwarding signals of the write-back block.
interface reg_writeback_if
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                res_valid;
    logic                res_ready;
    logic [DATA_W-1:0]   res_data;
    logic [ADDR_W-1:0]   res_addr;

    logic                rf_we;
    logic                rf_wready;
    logic [ADDR_W-1:0]   rf_waddr;
    logic [DATA_W-1:0]   rf_wdata;

    logic [ADDR_W-1:0]   fwd_addr;
    logic                fwd_hit;
    logic [DATA_W-1:0]   fwd_data;

    logic [NUM_REGS-1:0] pending;
    logic [CNT_W-1:0]    count;

    modport master (
        output res_valid, res_data, res_addr, rf_wready, fwd_addr,
        input  res_ready, rf_we, rf_waddr, rf_wdata, fwd_hit, fwd_data, pending, count
    );

    modport slave (
        input  res_valid, res_data, res_addr, rf_wready, fwd_addr,
        output res_ready, rf_we, rf_waddr, rf_wdata, fwd_hit, fwd_data, pending, count
    );

endinterface

// File: rtl/wb_fwd_match.sv
// Combinational forwarding lookup: picks the newest valid entry whose
// destination matches the requested register.
module wb_fwd_match
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  wb_entry_t         entries [DEPTH],
    input  logic [PTR_W-1:0]  wr_ptr,
    input  logic [ADDR_W-1:0] fwd_addr,
    output logic              hit,
    output logic [DATA_W-1:0] data
);

    logic [PTR_W-1:0] idx;

    // Walk from oldest (wr_ptr-DEPTH) to newest (wr_ptr-1) so later matches override.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = wr_ptr - PTR_W'(k);
            if (entries[idx].valid && (entries[idx].addr == fwd_addr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Write-back queue between the ALU result stream and the register bank write port,
// with a forwarding lookup over results that have not yet been written.
module reg_writeback
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_writeback_if.slave wb
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    wb_entry_t           entries [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count_q;
    logic                push;
    logic                pop;
    logic [NUM_REGS-1:0] pending_vec;

    assign wb.res_ready = (count_q != FULL);
    assign wb.rf_we     = (count_q != '0);
    assign push         = wb.res_valid && wb.res_ready;
    assign pop          = wb.rf_we && wb.rf_wready;

    // Head fields come straight from storage; a freshly pushed entry shows up next cycle.
    assign wb.rf_waddr  = entries[rd_ptr].addr;
    assign wb.rf_wdata  = entries[rd_ptr].data;
    assign wb.count     = count_q;
    assign wb.pending   = pending_vec;

    always_comb begin
        pending_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].valid) begin
                pending_vec[entries[i].addr] = 1'b1;
            end
        end
    end

    // Push and pop never share a slot: they coincide only when neither empty nor full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (pop) begin
                entries[rd_ptr].valid <= 1'b0;
                rd_ptr                <= rd_ptr + 1'b1;
            end
            if (push) begin
                entries[wr_ptr] <= '{valid: 1'b1, addr: wb.res_addr, data: wb.res_data};
                wr_ptr          <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    wb_fwd_match #(
        .DEPTH (DEPTH)
    ) u_fwd_match (
        .entries  (entries),
        .wr_ptr   (wr_ptr),
        .fwd_addr (wb.fwd_addr),
        .hit      (wb.fwd_hit),
        .data     (wb.fwd_data)
    );

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed vector table, reset corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_reg_writeback;
    import cpu_pkg::*;

    localparam int DEPTH = 2;

    typedef struct {
        logic        v;
        logic [2:0]  a;
        logic [15:0] d;
        logic        rdy;
        logic [2:0]  fa;
        logic        rr;
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        hit;
        logic [15:0] fd;
        logic [7:0]  pend;
        logic [1:0]  cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    vec_t        vecs [18];
    logic [2:0]  qa [$];
    logic [15:0] qd [$];

    always #5 clk = ~clk;

    reg_writeback_if #(.DEPTH(DEPTH)) wb ();

    reg_writeback #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic v, logic [2:0] a, logic [15:0] d, logic rdy, logic [2:0] fa,
                                logic rr, logic we, logic [2:0] wa, logic [15:0] wd,
                                logic hit, logic [15:0] fd, logic [7:0] pend, logic [1:0] cnt);
        vec_t t;
        t.v = v; t.a = a; t.d = d; t.rdy = rdy; t.fa = fa;
        t.rr = rr; t.we = we; t.wa = wa; t.wd = wd;
        t.hit = hit; t.fd = fd; t.pend = pend; t.cnt = cnt;
        return t;
    endfunction

    task automatic applyStimulus(input logic v, input logic [2:0] a, input logic [15:0] d,
                                 input logic rdy, input logic [2:0] fa);
        wb.res_valid = v;
        wb.res_addr  = a;
        wb.res_data  = d;
        wb.rf_wready = rdy;
        wb.fwd_addr  = fa;
    endtask

    task automatic checkOutput(input string tag, input vec_t t);
        chk({tag, " res_ready"}, 32'(wb.res_ready), 32'(t.rr));
        chk({tag, " rf_we"},     32'(wb.rf_we),     32'(t.we));
        if (t.we) begin
            chk({tag, " rf_waddr"}, 32'(wb.rf_waddr), 32'(t.wa));
            chk({tag, " rf_wdata"}, 32'(wb.rf_wdata), 32'(t.wd));
        end
        chk({tag, " fwd_hit"},  32'(wb.fwd_hit),  32'(t.hit));
        chk({tag, " fwd_data"}, 32'(wb.fwd_data), 32'(t.fd));
        chk({tag, " pending"},  32'(wb.pending),  32'(t.pend));
        chk({tag, " count"},    32'(wb.count),    32'(t.cnt));
    endtask

    // Expected outputs derived from the model queue contents (oldest at index 0).
    task automatic checkModel(input int cyc);
        vec_t        t;
        logic [7:0]  pend = '0;
        logic        hit  = 1'b0;
        logic [15:0] fd   = '0;
        int          n    = qa.size();
        foreach (qa[i]) pend[qa[i]] = 1'b1;
        for (int i = n - 1; i >= 0; i--) begin
            if (!hit && qa[i] == wb.fwd_addr) begin
                hit = 1'b1;
                fd  = qd[i];
            end
        end
        t = mk(1'b0, 3'd0, 16'd0, 1'b0, 3'd0,
               (n < DEPTH), (n > 0), (n > 0) ? qa[0] : 3'd0, (n > 0) ? qd[0] : 16'd0,
               hit, fd, pend, 2'(n));
        checkOutput($sformatf("rand%0d", cyc), t);
    endtask

    initial begin
        vecs[0]  = mk(1, 3, 16'hBEEF, 1, 3,  1, 0, 0, 16'h0000,  0, 16'h0000, 8'h00, 0);
        vecs[1]  = mk(0, 0, 16'h0000, 1, 3,  1, 1, 3, 16'hBEEF,  1, 16'hBEEF, 8'h08, 1);
        vecs[2]  = mk(0, 0, 16'h0000, 1, 3,  1, 0, 0, 16'h0000,  0, 16'h0000, 8'h00, 0);
        vecs[3]  = mk(1, 1, 16'h0011, 0, 1,  1, 0, 0, 16'h0000,  0, 16'h0000, 8'h00, 0);
        vecs[4]  = mk(1, 2, 16'h0022, 0, 1,  1, 1, 1, 16'h0011,  1, 16'h0011, 8'h02, 1);
        vecs[5]  = mk(1, 4, 16'h0044, 0, 2,  0, 1, 1, 16'h0011,  1, 16'h0022, 8'h06, 2);
        vecs[6]  = mk(1, 4, 16'h0044, 1, 4,  0, 1, 1, 16'h0011,  0, 16'h0000, 8'h06, 2);
        vecs[7]  = mk(1, 4, 16'h0044, 1, 4,  1, 1, 2, 16'h0022,  0, 16'h0000, 8'h04, 1);
        vecs[8]  = mk(0, 0, 16'h0000, 1, 4,  1, 1, 4, 16'h0044,  1, 16'h0044, 8'h10, 1);
        vecs[9]  = mk(0, 0, 16'h0000, 0, 4,  1, 0, 0, 16'h0000,  0, 16'h0000, 8'h00, 0);
        vecs[10] = mk(1, 5, 16'h1111, 0, 5,  1, 0, 0, 16'h0000,  0, 16'h0000, 8'h00, 0);
        vecs[11] = mk(1, 5, 16'h2222, 0, 5,  1, 1, 5, 16'h1111,  1, 16'h1111, 8'h20, 1);
        vecs[12] = mk(0, 0, 16'h0000, 0, 5,  0, 1, 5, 16'h1111,  1, 16'h2222, 8'h20, 2);
        vecs[13] = mk(0, 0, 16'h0000, 0, 6,  0, 1, 5, 16'h1111,  0, 16'h0000, 8'h20, 2);
        vecs[14] = mk(0, 0, 16'h0000, 1, 5,  0, 1, 5, 16'h1111,  1, 16'h2222, 8'h20, 2);
        vecs[15] = mk(1, 0, 16'hACCE, 1, 5,  1, 1, 5, 16'h2222,  1, 16'h2222, 8'h20, 1);
        vecs[16] = mk(0, 0, 16'h0000, 0, 0,  1, 1, 0, 16'hACCE,  1, 16'hACCE, 8'h01, 1);
        vecs[17] = mk(1, 7, 16'h7777, 0, 7,  1, 1, 0, 16'hACCE,  0, 16'h0000, 8'h01, 1);

        // Reset held for two cycles, then idle.
        rst_n = 1'b0;
        applyStimulus(1'b0, 3'd0, 16'd0, 1'b0, 3'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle", mk(0, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 8'h00, 0));
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].rdy, vecs[i].fa);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i), vecs[i]);
            @(posedge clk);
            #1;
        end

        // Two entries queued; asynchronous reset mid-cycle must clear outputs before the next edge.
        applyStimulus(1'b0, 3'd0, 16'd0, 1'b0, 3'd7);
        #2;
        chk("pre-reset count", 32'(wb.count), 32'd2);
        rst_n = 1'b0;
        #1;
        checkOutput("async-reset", mk(0, 0, 0, 0, 7,  1, 0, 0, 0,  0, 0, 8'h00, 0));
        chk("async-reset rf_waddr", 32'(wb.rf_waddr), 32'd0);
        chk("async-reset rf_wdata", 32'(wb.rf_wdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wb.rf_wready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post-reset%0d rf_we", i), 32'(wb.rf_we), 32'd0);
            chk($sformatf("post-reset%0d count", i), 32'(wb.count), 32'd0);
        end

        // Randomized traffic against the queue model.
        for (int c = 0; c < 400; c++) begin
            logic        v;
            logic        rdy;
            logic        do_pop;
            logic        do_push;
            logic [2:0]  a;
            logic [15:0] d;
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) == 0) || (c >= 200 && $urandom_range(0, 1) == 0);
            a   = 3'($urandom_range(0, 7));
            d   = 16'($urandom);
            applyStimulus(v, a, d, rdy, 3'($urandom_range(0, 7)));
            @(negedge clk);
            checkModel(c);
            do_pop  = rdy && (qa.size() > 0);
            do_push = v && (qa.size() < DEPTH);
            if (do_pop) begin
                void'(qa.pop_front());
                void'(qd.pop_front());
            end
            if (do_push) begin
                qa.push_back(a);
                qd.push_back(d);
            end
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
